// File: rtl/det_seq.sv
// det_seq: sequential fraction-free (Bareiss) determinant of a runtime-sized n x n signed matrix.
//   Optional build macro: DET_SATURATE_EN clamps an out-of-range det instead of truncating it.
//   Ports:
//     clk     in   system clock, rising edge
//     rst     in   asynchronous active-low reset
//     start   in   request pulse, sampled only while idle
//     size    in   matrix dimension n, sampled with start
//     matrix  in   MAX_N*MAX_N elements, row-major, element (0,0) in the MSBs
//     busy    out  high from the cycle after start acceptance until done
//     done    out  one-cycle pulse when det/ovf are valid
//     det     out  signed determinant (ELEM_W bits)
//     ovf     out  result/intermediate out of range, or illegal size
module det_seq #(
    parameter int MAX_N  = 5,
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(MAX_N+1)-1:0]    size,
    input  logic [MAX_N*MAX_N*ELEM_W-1:0] matrix,
    output logic                          busy,
    output logic                          done,
    output logic [ELEM_W-1:0]             det,
    output logic                          ovf
);
    localparam int SW = $clog2(MAX_N+1);
    localparam int PW = 2*ACC_W;
    localparam logic [SW-1:0] MAXN = SW'(MAX_N);

    typedef enum logic [2:0] {IDLE, LOAD, PIVOT, SWAP, ELIM, NEXT, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           n_q, n_d, k_q, k_d, r_q, r_d, i_q, i_d, j_q, j_d;
    logic signed [ACC_W-1:0] prev_q, prev_d;
    logic                    neg_q, neg_d, iflag_q, iflag_d, zero_q, zero_d, err_q, err_d;
    logic signed [ACC_W-1:0] a_q [MAX_N][MAX_N];
    logic signed [ACC_W-1:0] a_d [MAX_N][MAX_N];
    logic                    busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic [ELEM_W-1:0]       det_q, det_d;
    logic signed [PW-1:0]    prod, quot;
    logic signed [ACC_W:0]   res;
    logic                    fits, oor;

    assign busy = busy_q;
    assign done = done_q;
    assign det  = det_q;
    assign ovf  = ovf_q;

    always_comb begin
        // Bareiss update for the current (i,j); the division by the previous pivot is exact
        prod = PW'(a_q[k_q][k_q]) * PW'(a_q[i_q][j_q]) - PW'(a_q[i_q][k_q]) * PW'(a_q[k_q][j_q]);
        quot = prod / PW'(prev_q);
        fits = (&quot[PW-1:ACC_W-1]) | ~(|quot[PW-1:ACC_W-1]);
        // one extra bit so negating the most negative stored value cannot wrap
        res  = zero_q ? '0 :
               neg_q  ? -(ACC_W+1)'(a_q[n_q-1'b1][n_q-1'b1]) : (ACC_W+1)'(a_q[n_q-1'b1][n_q-1'b1]);
        oor  = ~((&res[ACC_W:ELEM_W-1]) | ~(|res[ACC_W:ELEM_W-1]));
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        r_d     = r_q;
        i_d     = i_q;
        j_d     = j_q;
        prev_d  = prev_q;
        neg_d   = neg_q;
        iflag_d = iflag_q;
        zero_d  = zero_q;
        err_d   = err_q;
        a_d     = a_q;
        done_d  = 1'b0;
        det_d   = det_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                state_d = start ? LOAD : IDLE;
                n_d     = start ? size : n_q;
            end
            LOAD: begin
                for (int r = 0; r < MAX_N; r++)
                    for (int c = 0; c < MAX_N; c++)
                        a_d[r][c] = (r < int'(n_q) && c < int'(n_q)) ?
                            ACC_W'($signed(matrix[(MAX_N*MAX_N-1-(r*MAX_N+c))*ELEM_W +: ELEM_W])) : '0;
                prev_d  = ACC_W'(1);
                neg_d   = 1'b0;
                k_d     = '0;
                r_d     = '0;
                iflag_d = 1'b0;
                zero_d  = 1'b0;
                err_d   = (n_q == '0) || (n_q > MAXN);
                state_d = ((n_q == '0) || (n_q > MAXN) || (n_q == SW'(1))) ? FINISH : PIVOT;
            end
            PIVOT: begin
                if (a_q[r_q][k_q] != '0) begin
                    state_d = (r_q == k_q) ? ELIM : SWAP;
                    i_d     = k_q + 1'b1;
                    j_d     = k_q + 1'b1;
                end else begin
                    r_d     = r_q + 1'b1;
                    zero_d  = (r_q + 1'b1 == n_q);
                    state_d = (r_q + 1'b1 == n_q) ? FINISH : PIVOT;
                end
            end
            SWAP: begin
                // columns left of k are already eliminated and never read again
                for (int c = 0; c < MAX_N; c++)
                    if (c >= int'(k_q) && c < int'(n_q)) begin
                        a_d[k_q][c] = a_q[r_q][c];
                        a_d[r_q][c] = a_q[k_q][c];
                    end
                neg_d   = ~neg_q;
                state_d = ELIM;
            end
            ELIM: begin
                a_d[i_q][j_q] = quot[ACC_W-1:0];
                iflag_d = iflag_q | ~fits;
                j_d     = (j_q == n_q - 1'b1) ? k_q + 1'b1 : j_q + 1'b1;
                i_d     = (j_q == n_q - 1'b1) ? i_q + 1'b1 : i_q;
                state_d = (j_q == n_q - 1'b1 && i_q == n_q - 1'b1) ? NEXT : ELIM;
            end
            NEXT: begin
                prev_d  = a_q[k_q][k_q];
                k_d     = k_q + 1'b1;
                r_d     = k_q + 1'b1;
                state_d = (k_q + 1'b1 == n_q - 1'b1) ? FINISH : PIVOT;
            end
            FINISH: begin
                done_d  = 1'b1;
                ovf_d   = err_q | iflag_q | oor;
`ifdef DET_SATURATE_EN
                det_d   = err_q ? '0 :
                          !oor  ? res[ELEM_W-1:0] :
                          res[ACC_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
`else
                det_d   = err_q ? '0 : res[ELEM_W-1:0];
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_q != IDLE) && (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            prev_q  <= '0;
            neg_q   <= 1'b0;
            iflag_q <= 1'b0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
            a_q     <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            det_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            r_q     <= r_d;
            i_q     <= i_d;
            j_q     <= j_d;
            prev_q  <= prev_d;
            neg_q   <= neg_d;
            iflag_q <= iflag_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            det_q   <= det_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_det_seq.sv
// tb_det_seq: directed and randomized checks of det_seq against a permutation-expansion model.
module tb_det_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   size = '0;
    logic [199:0] matrix = '0;
    logic         busy, done, ovf;
    logic [7:0]   det;
    int           tests = 0;
    int           fails = 0;
    int           em [5][5];
    int           lat, bcnt, cnt;
    bit           bz;

    always #5 clk = ~clk;

    det_seq dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .matrix(matrix),
        .busy(busy), .done(done), .det(det), .ovf(ovf)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Leibniz expansion over all permutations of the top-left n x n block
    function automatic longint ref_det(input int n);
        longint s, t;
        int     tot, x, inv;
        int     p [5];
        bit     ok;
        s = 0;
        tot = 1;
        for (int i = 0; i < n; i++) tot *= n;
        for (int d = 0; d < tot; d++) begin
            x = d;
            ok = 1;
            inv = 0;
            for (int i = 0; i < n; i++) begin p[i] = x % n; x = x / n; end
            for (int i = 0; i < n; i++)
                for (int j = i + 1; j < n; j++) begin
                    if (p[i] == p[j]) ok = 0;
                    if (p[i] > p[j]) inv++;
                end
            if (ok) begin
                t = 1;
                for (int i = 0; i < n; i++) t *= longint'(em[i][p[i]]);
                s += (inv % 2 == 1) ? -t : t;
            end
        end
        return s;
    endfunction

    function automatic logic [7:0] exp_det8(input longint d);
`ifdef DET_SATURATE_EN
        if (d > 127) return 8'h7F;
        if (d < -128) return 8'h80;
`endif
        return d[7:0];
    endfunction

    task automatic fill(input int lo, input int hi);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                em[r][c] = int'($urandom_range(hi - lo)) + lo;
    endtask

    task automatic run(input int n, input bit ign, output int l, output int b, output bit bd);
        bit got;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                matrix[(24 - (r*5 + c))*8 +: 8] = 8'(em[r][c]);
        @(negedge clk);
        size = 3'(n);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        l = 0;
        b = 0;
        bd = 0;
        got = 0;
        while (!got && l < 300) begin
            @(posedge clk);
            #1 l++;
            if (done) begin got = 1; bd = busy; end
            else if (busy) b++;
            if (ign && l == 3) begin size = 3'(1); start = 1'b1; end
            if (ign && l == 4) begin size = 3'(n); start = 1'b0; end
        end
        chk("done_arrived", longint'(got), 1);
    endtask

    task automatic rand_case(input int n, input int lo, input int hi);
        longint d;
        fill(lo, hi);
        d = ref_det(n);
        run(n, 0, lat, bcnt, bz);
        chk("rand_det", longint'(det), longint'(exp_det8(d)));
        chk("rand_ovf", longint'(ovf), longint'(d > 127 || d < -128));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_det", longint'(det), 0);
        chk("rst_ovf", longint'(ovf), 0);
        @(negedge clk) rst = 1'b1;

        fill(-128, 127);
        em[0][0] = 2; em[0][1] = 1; em[0][2] = 0;
        em[1][0] = 1; em[1][1] = 3; em[1][2] = 1;
        em[2][0] = 0; em[2][1] = 1; em[2][2] = 4;
        run(3, 0, lat, bcnt, bz);
        chk("n3_latency", lat, 11);
        chk("n3_busy_cycles", bcnt, 10);
        chk("n3_busy_at_done", longint'(bz), 0);
        chk("n3_det", longint'(det), 18);
        chk("n3_ovf", longint'(ovf), 0);
        @(posedge clk);
        #1 chk("n3_done_pulse", longint'(done), 0);
        chk("n3_det_hold", longint'(det), 18);

        fill(-128, 127);
        em[0][0] = 0; em[0][1] = 1; em[1][0] = 1; em[1][1] = 0;
        run(2, 0, lat, bcnt, bz);
        chk("swap_latency", lat, 7);
        chk("swap_det", longint'(det), 8'hFF);
        chk("swap_ovf", longint'(ovf), 0);

        fill(1, 9);
        em[0][0] = 0; em[1][0] = 0; em[2][0] = 0;
        run(3, 0, lat, bcnt, bz);
        chk("zcol_latency", lat, 5);
        chk("zcol_det", longint'(det), 0);
        chk("zcol_ovf", longint'(ovf), 0);

        fill(-128, 127);
        em[0][0] = 1; em[0][1] = 2; em[1][0] = 2; em[1][1] = 4;
        run(2, 0, lat, bcnt, bz);
        chk("sing_latency", lat, 5);
        chk("sing_det", longint'(det), 0);
        chk("sing_ovf", longint'(ovf), 0);

        fill(-128, 127);
        em[0][0] = -7;
        run(1, 0, lat, bcnt, bz);
        chk("n1_latency", lat, 2);
        chk("n1_det", longint'(det), 8'hF9);
        chk("n1_ovf", longint'(ovf), 0);

        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                em[r][c] = (r == c) ? 3 : 0;
        run(5, 0, lat, bcnt, bz);
        chk("diag_latency", lat, 40);
`ifdef DET_SATURATE_EN
        chk("diag_det", longint'(det), 127);
`else
        chk("diag_det", longint'(det), 8'hF3);
`endif
        chk("diag_ovf", longint'(ovf), 1);

        @(negedge clk);
        size = 3'(5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_det", longint'(det), 0);
        chk("abort_ovf", longint'(ovf), 0);
        @(negedge clk) rst = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(posedge clk);
            #1 if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        chk("abort_idle_busy", longint'(busy), 0);

        run(5, 1, lat, bcnt, bz);
        chk("rerun_latency", lat, 40);
`ifdef DET_SATURATE_EN
        chk("rerun_det", longint'(det), 127);
`else
        chk("rerun_det", longint'(det), 8'hF3);
`endif
        chk("rerun_ovf", longint'(ovf), 1);

        fill(-128, 127);
        run(0, 0, lat, bcnt, bz);
        chk("size0_det", longint'(det), 0);
        chk("size0_ovf", longint'(ovf), 1);
        run(6, 0, lat, bcnt, bz);
        chk("size6_det", longint'(det), 0);
        chk("size6_ovf", longint'(ovf), 1);

        for (int t = 0; t < 40; t++) begin
            if (t % 2 == 0) rand_case(int'($urandom_range(1, 5)), -3, 3);
            else rand_case(int'($urandom_range(1, 5)), -128, 127);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
